// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: executes one RS + byte item on an HD44780-style 8-bit bus.
// It drives setup, enable-pulse and hold timing for the write. Completion is
// then gated by either busy-flag polling or a fixed post-write delay.
module lcd_bus_driver #(
  parameter int T_SETUP   = 4,
  parameter int T_EN      = 16,
  parameter int T_HOLD    = 4,
  parameter bit BUSY_POLL = 1'b1,
  parameter int T_WAIT    = 2000,
  parameter int MAX_POLLS = 4095
) (
  input  logic       iCLK,
  input  logic       Reset,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // Last phase-counter value of each timed phase.
  localparam logic [15:0] SETUP_LAST = 16'(T_SETUP - 1);
  localparam logic [15:0] EN_LAST    = 16'(T_EN - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(T_HOLD - 1);
  localparam logic [15:0] WAIT_LAST  = 16'((T_WAIT > 0) ? (T_WAIT - 1) : 0);
  // Poll count value during the final permitted read.
  localparam logic [11:0] POLL_LIMIT = 12'(MAX_POLLS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_ENH,
    S_HOLD,
    S_WAIT,
    S_POLL_SETUP,
    S_POLL_EN,
    S_POLL_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] phase_cnt;
  logic [11:0] poll_cnt;
  logic        start_q;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        db7_q;
  logic        timeout_q;
  logic        accept;
  logic        phase_end;
  logic        read_mode;

  assign accept = (state == S_IDLE) && iStart && !start_q;

  // Next-state logic and end-of-phase detection for the current state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the case statement can leave it unassigned and infer a latch.
    state_n   = state;
    phase_end = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_SETUP;
      end
      S_SETUP: begin
        phase_end = (phase_cnt == SETUP_LAST);
        if (phase_end) state_n = S_ENH;
      end
      S_ENH: begin
        phase_end = (phase_cnt == EN_LAST);
        if (phase_end) state_n = S_HOLD;
      end
      S_HOLD: begin
        phase_end = (phase_cnt == HOLD_LAST);
        if (phase_end) begin
          if (BUSY_POLL)        state_n = S_POLL_SETUP;
          else if (T_WAIT == 0) state_n = S_DONE;
          else                  state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        phase_end = (phase_cnt == WAIT_LAST);
        if (phase_end) state_n = S_DONE;
      end
      S_POLL_SETUP: begin
        phase_end = (phase_cnt == SETUP_LAST);
        if (phase_end) state_n = S_POLL_EN;
      end
      S_POLL_EN: begin
        phase_end = (phase_cnt == EN_LAST);
        if (phase_end) state_n = S_POLL_HOLD;
      end
      S_POLL_HOLD: begin
        phase_end = (phase_cnt == HOLD_LAST);
        if (phase_end) begin
          if (!db7_q || (poll_cnt == POLL_LIMIT)) state_n = S_DONE;
          else                                    state_n = S_POLL_SETUP;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register, phase/poll counters, latched item and status flags.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      poll_cnt  <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      db7_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= iStart;

      if ((state == S_IDLE) || (state_n != state)) phase_cnt <= '0;
      else                                         phase_cnt <= phase_cnt + 16'd1;

      if (accept) begin
        data_q   <= iDATA;
        rs_q     <= iRS;
        poll_cnt <= '0;
      end

      // Busy flag is captured on the final cycle of the read strobe.
      if ((state == S_POLL_EN) && phase_end) db7_q <= LCD_DATA[7];

      if ((state == S_POLL_HOLD) && phase_end) begin
        poll_cnt <= poll_cnt + 12'd1;
        if (db7_q && (poll_cnt == POLL_LIMIT)) timeout_q <= 1'b1;
      end
    end
  end

  // Read mode covers the polls and the completion cycle after them; the bus
  // returns to driving the latched byte only once the driver is idle again.
  always_comb begin
    read_mode = (state == S_POLL_SETUP) || (state == S_POLL_EN) ||
                (state == S_POLL_HOLD)  || ((state == S_DONE) && BUSY_POLL);
  end

  assign LCD_EN   = (state == S_ENH) || (state == S_POLL_EN);
  assign LCD_RW   = read_mode;
  assign LCD_RS   = read_mode ? 1'b0 : rs_q;
  assign LCD_DATA = read_mode ? 8'hzz : data_q;
  assign oDone    = (state == S_DONE);
  assign oBusy    = (state != S_IDLE);
  assign oTimeout = timeout_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed bench for lcd_bus_driver. Three instances cover
// fixed-delay completion, busy polling, and poll timeout. A write scoreboard
// checks RS/byte order on the fixed-delay instance.
module tb_lcd_bus_driver;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Fixed-delay instance
  logic       fx_start, fx_rs;
  logic [7:0] fx_din;
  wire        fx_done, fx_busy, fx_tmo, fx_rw, fx_en, fx_lrs;
  wire  [7:0] fx_bus;

  lcd_bus_driver #(.T_SETUP(4), .T_EN(16), .T_HOLD(4), .BUSY_POLL(1'b0),
                   .T_WAIT(10), .MAX_POLLS(4095)) u_fx (
    .iCLK(clk), .Reset(rst), .iDATA(fx_din), .iRS(fx_rs), .iStart(fx_start),
    .oDone(fx_done), .oBusy(fx_busy), .oTimeout(fx_tmo), .LCD_DATA(fx_bus),
    .LCD_RW(fx_rw), .LCD_EN(fx_en), .LCD_RS(fx_lrs));

  // Busy-poll instance: the LCD model reports busy on the first read only.
  logic       pl_start;
  wire        pl_done, pl_busy, pl_tmo, pl_rw, pl_en, pl_lrs;
  wire  [7:0] pl_bus;
  int         pl_reads = 0;
  logic       pl_db7;

  assign pl_db7 = (pl_reads < 2);
  assign pl_bus = pl_rw ? {pl_db7, 7'h54} : 8'hzz;

  lcd_bus_driver #(.T_SETUP(4), .T_EN(16), .T_HOLD(4), .BUSY_POLL(1'b1),
                   .T_WAIT(2000), .MAX_POLLS(4095)) u_pl (
    .iCLK(clk), .Reset(rst), .iDATA(8'h01), .iRS(1'b0), .iStart(pl_start),
    .oDone(pl_done), .oBusy(pl_busy), .oTimeout(pl_tmo), .LCD_DATA(pl_bus),
    .LCD_RW(pl_rw), .LCD_EN(pl_en), .LCD_RS(pl_lrs));

  // Timeout instance: the LCD model's busy flag is set by the bench.
  logic       to_start;
  logic       to_db7;
  wire        to_done, to_busy, to_tmo, to_rw, to_en, to_lrs;
  wire  [7:0] to_bus;

  assign to_bus = to_rw ? {to_db7, 7'h54} : 8'hzz;

  lcd_bus_driver #(.T_SETUP(4), .T_EN(16), .T_HOLD(4), .BUSY_POLL(1'b1),
                   .T_WAIT(2000), .MAX_POLLS(3)) u_to (
    .iCLK(clk), .Reset(rst), .iDATA(8'h01), .iRS(1'b0), .iStart(to_start),
    .oDone(to_done), .oBusy(to_busy), .oTimeout(to_tmo), .LCD_DATA(to_bus),
    .LCD_RW(to_rw), .LCD_EN(to_en), .LCD_RS(to_lrs));

  logic [8:0] sb_q[$];
  int         fx_dones = 0;
  int         fx_en_rises = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_fx(input logic rs, input logic [7:0] d);
    fx_rs    = rs;
    fx_din   = d;
    fx_start = 1'b1;
    sb_q.push_back({rs, d});
  endtask

  task automatic wait_done_fx(input string tag);
    int n = 0;
    while (fx_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, fx_done}, 32'd1);
  endtask

  // Monitor shortly after each edge: scoreboard pops, strobe and done counts.
  logic fx_en_q = 1'b0;
  logic pl_en_q = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (fx_en && !fx_en_q) begin
      fx_en_rises++;
      if (!fx_rw) begin
        if (sb_q.size() == 0) check("sb_unexpected_write", sb_q.size(), 1);
        else check("sb_item", {23'd0, fx_lrs, fx_bus}, {23'd0, sb_q.pop_front()});
      end
    end
    if (fx_done) fx_dones++;
    if (pl_en && !pl_en_q && pl_rw) pl_reads++;
    fx_en_q = fx_en;
    pl_en_q = pl_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_first, en_last, en_cnt, done_cnt, done_at, busy_cnt, bad, bad_rw;
    int rw_cnt, rises, rw74, d0, r0;
    logic [7:0] bus74;
    logic prev_en, prev_rw;
    logic [8:0] init_seq [5];

    init_seq = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    fx_start = 0; fx_rs = 0; fx_din = 0;
    pl_start = 0; to_start = 0; to_db7 = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_en",   {31'd0, fx_en},   0);
    check("rst_rw",   {31'd0, fx_rw},   0);
    check("rst_rs",   {31'd0, fx_lrs},  0);
    check("rst_data", {24'd0, fx_bus},  32'h00);
    check("rst_done", {31'd0, fx_done}, 0);
    check("rst_busy", {31'd0, fx_busy}, 0);
    check("rst_tmo",  {31'd0, to_tmo},  0);
    rst = 0;
    @(negedge clk);

    // Fixed-delay write of data 8'h41
    start_fx(1'b1, 8'h41);
    en_first = 0; en_last = 0; en_cnt = 0; done_cnt = 0; done_at = 0;
    busy_cnt = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      fx_start = 0;
      if (fx_en) begin
        if (en_first == 0) en_first = k;
        en_last = k;
        en_cnt++;
      end
      if (fx_done) begin done_cnt++; done_at = k; end
      if (fx_busy) busy_cnt++;
      if (fx_bus !== 8'h41 || fx_lrs !== 1'b1 || fx_rw !== 1'b0) bad++;
    end
    check("fx_en_first", en_first, 5);
    check("fx_en_last",  en_last,  20);
    check("fx_en_cnt",   en_cnt,   16);
    check("fx_done_at",  done_at,  35);
    check("fx_done_cnt", done_cnt, 1);
    check("fx_busy_cnt", busy_cnt, 35);
    check("fx_bus_stable", bad, 0);

    // iStart held high for 200 cycles
    d0 = fx_dones; r0 = fx_en_rises;
    start_fx(1'b0, 8'h55);
    repeat (200) @(negedge clk);
    fx_start = 0;
    repeat (5) @(negedge clk);
    check("held_dones", fx_dones - d0, 1);
    check("held_rises", fx_en_rises - r0, 1);

    // Second rising edge during ENH is ignored
    d0 = fx_dones; r0 = fx_en_rises;
    start_fx(1'b1, 8'h66);
    @(negedge clk); fx_start = 0;
    repeat (8) @(negedge clk);
    check("enh_en", {31'd0, fx_en}, 1);
    fx_start = 1;
    @(negedge clk); fx_start = 0;
    repeat (40) @(negedge clk);
    check("retrig_dones", fx_dones - d0, 1);
    check("retrig_rises", fx_en_rises - r0, 1);
    check("retrig_idle",  {31'd0, fx_busy}, 0);

    // Reset during ENH aborts the transfer
    start_fx(1'b1, 8'h77);
    @(negedge clk); fx_start = 0;
    repeat (7) @(negedge clk);
    check("mid_en_before", {31'd0, fx_en}, 1);
    rst = 1;
    @(negedge clk);
    check("mid_en",   {31'd0, fx_en},   0);
    check("mid_data", {24'd0, fx_bus},  32'h00);
    check("mid_busy", {31'd0, fx_busy}, 0);
    check("mid_done", {31'd0, fx_done}, 0);
    check("mid_rs",   {31'd0, fx_lrs},  0);
    rst = 0;
    d0 = fx_dones;
    repeat (40) @(negedge clk);
    check("mid_no_done", fx_dones - d0, 0);
    start_fx(1'b0, 8'h12);
    @(negedge clk); fx_start = 0;
    wait_done_fx("after_reset_done");
    @(negedge clk);

    // LCD init sequence, back to back
    d0 = fx_dones;
    for (int i = 0; i < 5; i++) begin
      start_fx(init_seq[i][8], init_seq[i][7:0]);
      @(negedge clk); fx_start = 0;
      wait_done_fx("init_done");
      @(negedge clk);
    end
    check("init_dones", fx_dones - d0, 5);
    check("sb_drained", sb_q.size(), 0);

    // Two busy polls: DB7=1 on first read, 0 on second
    pl_start = 1;
    rw_cnt = 0; rises = 0; done_at = 0; done_cnt = 0; bad = 0; bad_rw = 0;
    rw74 = 0; bus74 = 8'h00; prev_en = 0; prev_rw = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      pl_start = 0;
      if (pl_en && !prev_en) rises++;
      if (pl_rw) rw_cnt++;
      if (pl_done) begin done_cnt++; done_at = k; end
      if (k <= 24 && pl_bus !== 8'h01) bad++;
      if (pl_rw && (pl_bus !== {pl_db7, 7'h54} || pl_lrs !== 1'b0)) bad++;
      if ((pl_rw != prev_rw) && (pl_en || prev_en)) bad_rw++;
      if (k == 74) begin rw74 = pl_rw; bus74 = pl_bus; end
      prev_en = pl_en; prev_rw = pl_rw;
    end
    check("pl_rises",    rises,    3);
    check("pl_reads",    pl_reads, 2);
    check("pl_rw_cnt",   rw_cnt,   49);
    check("pl_done_at",  done_at,  73);
    check("pl_done_cnt", done_cnt, 1);
    check("pl_bus",      bad,      0);
    check("pl_rw_vs_en", bad_rw,   0);
    check("pl_rw_after", rw74,     0);
    check("pl_bus_after", {24'd0, bus74}, 32'h01);
    check("pl_tmo",      {31'd0, pl_tmo}, 0);

    // Poll timeout with DB7 stuck high
    to_db7 = 1; to_start = 1;
    rises = 0; done_at = 0; done_cnt = 0; prev_en = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      to_start = 0;
      if (to_en && !prev_en && to_rw) rises++;
      if (to_done) begin done_cnt++; done_at = k; end
      prev_en = to_en;
    end
    check("to_reads",    rises,    3);
    check("to_done_at",  done_at,  97);
    check("to_done_cnt", done_cnt, 1);
    check("to_tmo_set",  {31'd0, to_tmo}, 1);

    // Successful transfer afterwards keeps the flag
    to_db7 = 0; to_start = 1;
    @(negedge clk); to_start = 0;
    begin
      int n = 0;
      while (to_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("to_second_done", {31'd0, to_done}, 1);
    end
    repeat (5) @(negedge clk);
    check("to_tmo_sticky", {31'd0, to_tmo}, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("to_tmo_cleared", {31'd0, to_tmo}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
